// File: rtl/condition_register.sv
// -----------------------------------------------------------------------------
// condition_register
//
// Captures the ALU condition flags (Z, C, S) into the sequencer-visible
// condition register once the ALU outputs have stayed unchanged for
// SETTLE_CYCLES consecutive clock edges. This models relay settle time on the
// result/zero/carry lines. The block also cross-checks the captured zero-detect
// signal against the captured result bits. It raises a sticky error when the
// two disagree.
//
// Parameters
//   SETTLE_CYCLES : consecutive stable edges required before capture (1..15)
//
// Ports
//   clk       in   system clock, rising-edge active
//   reset_n   in   asynchronous active-low reset
//   ld_req    in   load request, honoured only while idle
//   clr_req   in   clear request: zeroes the flags and aborts a pending load
//   result    in   8-bit ALU result bus
//   zero      in   ALU zero-detect (expected 1 when result == 0)
//   carry     in   ALU carry out
//   flag_z    out  latched zero flag
//   flag_c    out  latched carry flag
//   flag_s    out  latched sign flag (captured result[7])
//   busy      out  high while waiting for the inputs to settle
//   done      out  one-cycle pulse following a flag update
//   zero_err  out  sticky zero-detect disagreement, cleared only by reset
// -----------------------------------------------------------------------------
module condition_register #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ld_req,
  input  logic       clr_req,
  input  logic [7:0] result,
  input  logic       zero,
  input  logic       carry,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_s,
  output logic       busy,
  output logic       done,
  output logic       zero_err
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SETTLE = 1'b1
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_nxt;

  // Snapshot layout: {result[7:0], zero, carry}
  logic [9:0] r_snap;
  logic [3:0] r_cnt;

  logic       r_flag_z;
  logic       r_flag_c;
  logic       r_flag_s;
  logic       r_done;
  logic       r_zero_err;

  logic [9:0] w_in;
  logic       w_match;
  logic       w_cnt_last;

  // Per-cycle control strobes, decoded from state and inputs
  logic       w_load;
  logic       w_restart;
  logic       w_capture;
  logic       w_cnt_inc;
  logic       w_clear;

  // True when the captured zero-detect bit disagrees with the captured result
  function automatic logic zero_mismatch(input logic [9:0] snap);
    logic [7:0] res;
    logic       z;
    res = snap[9:2];
    z   = snap[1];
    return z != (res == 8'h00);
  endfunction

  assign w_in       = {result, zero, carry};
  assign w_match    = (w_in == r_snap);
  assign w_cnt_last = (r_cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        // A clear in the same cycle swallows the load request.
        if (ld_req && !clr_req) begin
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (clr_req) begin
          w_state_nxt = S_IDLE;
        end else if (w_match && w_cnt_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_load    = 1'b0;
    w_restart = 1'b0;
    w_capture = 1'b0;
    w_cnt_inc = 1'b0;
    w_clear   = clr_req;
    busy      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_load = ld_req && !clr_req;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (!clr_req) begin
          // Any change on the watched inputs restarts the settle window.
          if (!w_match) begin
            w_restart = 1'b1;
          end else if (w_cnt_last) begin
            w_capture = 1'b1;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Snapshot and settle counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_load || w_restart) begin
        r_snap <= w_in;
        r_cnt  <= '0;
      end else if (w_cnt_inc) begin
        r_cnt  <= r_cnt + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Condition flags, done pulse and sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flag_z   <= 1'b0;
      r_flag_c   <= 1'b0;
      r_flag_s   <= 1'b0;
      r_done     <= 1'b0;
      r_zero_err <= 1'b0;
    end else begin
      r_done <= w_capture;
      if (w_clear) begin
        r_flag_z <= 1'b0;
        r_flag_c <= 1'b0;
        r_flag_s <= 1'b0;
      end else if (w_capture) begin
        r_flag_z <= r_snap[1];
        r_flag_c <= r_snap[0];
        r_flag_s <= r_snap[9];
      end
      // Sticky: only reset clears it; clr_req deliberately leaves it alone.
      if (w_capture && zero_mismatch(r_snap)) begin
        r_zero_err <= 1'b1;
      end
    end
  end

  assign flag_z   = r_flag_z;
  assign flag_c   = r_flag_c;
  assign flag_s   = r_flag_s;
  assign done     = r_done;
  assign zero_err = r_zero_err;

endmodule

// File: tb/tb_condition_register.sv
module tb_condition_register;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ld_req;
  logic       clr_req;
  logic [7:0] result;
  logic       zero;
  logic       carry;
  logic       flag_z, flag_c, flag_s, busy, done, zero_err;

  always #5 clk = ~clk;

  condition_register #(.SETTLE_CYCLES(SC)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ld_req   (ld_req),
    .clr_req  (clr_req),
    .result   (result),
    .zero     (zero),
    .carry    (carry),
    .flag_z   (flag_z),
    .flag_c   (flag_c),
    .flag_s   (flag_s),
    .busy     (busy),
    .done     (done),
    .zero_err (zero_err)
  );

  typedef struct packed {
    logic z, c, s, busy, done, err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: a pending load remembers the input tuple it is watching and
  // the edge number at which that tuple was last (re)taken. It fires once
  // SC edges have elapsed without any change.
  bit         m_pending;
  logic [7:0] m_res;
  logic       m_zero, m_carry;
  int         m_since;
  int         m_edge;
  logic       m_z, m_c, m_s, m_done, m_err;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pending = 0;
    m_res = 8'h00; m_zero = 0; m_carry = 0;
    m_since = 0; m_edge = 0;
    m_z = 0; m_c = 0; m_s = 0; m_done = 0; m_err = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_step();
    exp_t e;
    m_edge++;
    m_done = 0;
    if (clr_req) begin
      m_z = 0; m_c = 0; m_s = 0;
      m_pending = 0;
    end else if (!m_pending) begin
      if (ld_req) begin
        m_pending = 1;
        m_res = result; m_zero = zero; m_carry = carry;
        m_since = m_edge;
      end
    end else if (result != m_res || zero != m_zero || carry != m_carry) begin
      m_res = result; m_zero = zero; m_carry = carry;
      m_since = m_edge;
    end else if (m_edge - m_since >= SC) begin
      m_z = m_zero; m_c = m_carry; m_s = m_res[7];
      m_done = 1;
      m_pending = 0;
      if (m_zero != (m_res == 8'h00)) m_err = 1;
    end
    e.z = m_z; e.c = m_c; e.s = m_s;
    e.busy = m_pending; e.done = m_done; e.err = m_err;
    q.push_back(e);
  endtask

  // Monitor: every falling edge the DUT presents its registered outputs.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("flag_z", flag_z, e.z);
      chk("flag_c", flag_c, e.c);
      chk("flag_s", flag_s, e.s);
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      chk("zero_err", zero_err, e.err);
    end
  end

  task automatic cyc(input logic ld, input logic clr, input logic [7:0] r,
                     input logic z, input logic c);
    @(negedge clk); #1;
    ld_req = ld; clr_req = clr; result = r; zero = z; carry = c;
    @(posedge clk);
    model_step();
  endtask

  // Assert reset between edges and confirm outputs drop before the next edge.
  task automatic async_rst();
    @(negedge clk); #2;
    ld_req = 0; clr_req = 0;
    reset_n = 0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_flag_z", flag_z, 1'b0);
    chk("arst_flag_c", flag_c, 1'b0);
    chk("arst_flag_s", flag_s, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_zero_err", zero_err, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk); #1;
    reset_n = 1;
    @(posedge clk);
    model_step();
  endtask

  logic [7:0] cur_r;
  logic       cur_z, cur_c;

  initial begin
    reset_n = 0; ld_req = 0; clr_req = 0; result = 8'h00; zero = 0; carry = 0;
    model_reset();
    #12;
    chk("rst_flag_z", flag_z, 1'b0);
    chk("rst_flag_c", flag_c, 1'b0);
    chk("rst_flag_s", flag_s, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_zero_err", zero_err, 1'b0);
    @(negedge clk); #1;
    reset_n = 1;
    @(posedge clk);
    model_step();

    // Stable capture
    cyc(1, 0, 8'h80, 0, 1);
    repeat (6) cyc(0, 0, 8'h80, 0, 1);

    // Glitch restart
    cyc(1, 0, 8'h00, 1, 0);
    cyc(0, 0, 8'h00, 1, 0);
    cyc(0, 0, 8'h01, 1, 0);
    repeat (7) cyc(0, 0, 8'h00, 1, 0);

    // Clear priority during a load, then ld+clr together in idle
    cyc(1, 0, 8'hFF, 0, 1);
    cyc(0, 0, 8'hFF, 0, 1);
    cyc(0, 0, 8'hFF, 0, 1);
    cyc(0, 1, 8'hFF, 0, 1);
    cyc(0, 0, 8'hFF, 0, 1);
    cyc(1, 1, 8'hFF, 0, 1);
    repeat (3) cyc(0, 0, 8'hFF, 0, 1);

    // Zero mismatch, sticky across clr_req
    cyc(1, 0, 8'h10, 1, 0);
    repeat (5) cyc(0, 0, 8'h10, 1, 0);
    cyc(0, 1, 8'h10, 1, 0);
    cyc(0, 0, 8'h10, 1, 0);

    // Back-to-back with ld_req held high
    repeat (16) cyc(1, 0, 8'h81, 0, 0);
    // Pulsed ld_req inside a load is ignored
    cyc(1, 0, 8'h02, 0, 1);
    cyc(0, 0, 8'h02, 0, 1);
    cyc(1, 0, 8'h02, 0, 1);
    repeat (4) cyc(0, 0, 8'h02, 0, 1);

    // Async reset mid-settle after a capture left flags set
    cyc(1, 0, 8'h80, 0, 1);
    repeat (5) cyc(0, 0, 8'h80, 0, 1);
    cyc(1, 0, 8'h33, 0, 0);
    cyc(0, 0, 8'h33, 0, 0);
    async_rst();
    repeat (6) cyc(0, 0, 8'h33, 0, 0);

    // Randomized traffic
    cur_r = 8'h00; cur_z = 1; cur_c = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: cur_r = 8'h00;
          1: cur_r = 8'h80;
          default: cur_r = 8'($urandom);
        endcase
        cur_z = (cur_r == 8'h00);
        if ($urandom_range(0, 9) == 0) cur_z = ~cur_z;
        cur_c = 1'($urandom);
      end
      cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0), cur_r, cur_z, cur_c);
      if (i == 300) async_rst();
    end

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
